// File: rtl/gol_pattern_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gol_pattern_loader: serial seed stream -> flat initialState + initialize  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module gol_pattern_loader #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  localparam int N    = ROWS * COLS,
  localparam int IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic            bit_in,
  input  logic            bit_valid,
  output logic            bit_ready,
  output logic [N-1:0]    initialState,
  output logic            initialize,
  output logic            busy,
  output logic            done,
  output logic [IDXW-1:0] load_idx
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  logic [1:0]      state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [N-1:0]    vec_q, vec_d;
  logic            init_q, init_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            xfer;

  assign bit_ready = (state_q == S_LOAD);
  // abort wins over a same-cycle handshake, so that bit is never written
  assign xfer      = bit_ready && bit_valid && !abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
      init_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      init_q  <= init_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (abort)                    state_d = S_IDLE;
        else if (xfer && idx_q == LAST_IDX) state_d = S_COMMIT;
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Registered outputs are derived from the next state so they line up with it
  always_comb begin
    idx_d  = idx_q;
    vec_d  = vec_q;
    init_d = (state_d != S_IDLE);
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_COMMIT);
    if (state_q == S_IDLE && start) begin
      idx_d = '0;
    end
    if (xfer) begin
      vec_d[idx_q] = bit_in;
      idx_d        = (idx_q == LAST_IDX) ? '0 : idx_q + IDXW'(1);
    end
  end

  assign initialState = vec_q;
  assign initialize   = init_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign load_idx     = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_gol_pattern_loader.sv
`default_nettype none
// Bench for gol_pattern_loader on a 4x4 board with a behavioural Life array fed by the loader.
module tb_gol_pattern_loader;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        bit_ready;
  logic [15:0] initialState;
  logic        initialize;
  logic        busy;
  logic        done;
  logic [3:0]  load_idx;

  gol_pattern_loader #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .bit_ready    (bit_ready),
    .initialState (initialState),
    .initialize   (initialize),
    .busy         (busy),
    .done         (done),
    .load_idx     (load_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pat;
    int          ilen;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks   = 0;
  int          errors   = 0;
  int          done_cnt = 0;
  int          run_len  = 0;
  logic [15:0] board    = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Life step on a 4x4 board with dead cells outside the edge
  function automatic logic [15:0] life(input logic [15:0] b);
    logic [15:0] nb;
    nb = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        int n;
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < ROWS &&
                c + dc >= 0 && c + dc < COLS)
              n += int'(b[(r + dr) * COLS + (c + dc)]);
          end
        end
        nb[r * COLS + c] = (n == 3) || (b[r * COLS + c] && n == 2);
      end
    end
    return nb;
  endfunction

  always @(posedge clk) begin
    if (initialize) board <= initialState;
    else            board <= life(board);
  end

  // Scoreboard monitor: each done pulse retires one queued expectation
  always @(negedge clk) begin
    if (initialize) begin
      run_len++;
    end else begin
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: got done=1 required no done at %0t", $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("commit_vec", 32'(initialState), 32'(mon_e.pat));
          chk("init_cycles", run_len, mon_e.ilen);
          chk("idx_after_done", 32'(load_idx), 0);
        end
      end
      run_len = 0;
    end
  end

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    int guard;
    bit_in    = b;
    bit_valid = 1'b1;
    guard     = 0;
    while (!bit_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) chk("ready_timeout", 0, 1);
    @(posedge clk); #1;
    bit_valid = 1'b0;
  endtask

  task automatic load_pat(input logic [15:0] pat, input int stall_at, input int stall_len,
                          input int start_at);
    for (int i = 0; i < 16; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          bit_valid = 1'b0;
          @(negedge clk);
          chk("stall_idx", 32'(load_idx), i);
          chk("stall_ready", 32'(bit_ready), 1);
          @(posedge clk); #1;
        end
      end
      if (i == start_at) start = 1'b1;
      send_bit(pat[i]);
      if (i == start_at) begin
        start = 1'b0;
        chk("start_in_load_idx", 32'(load_idx), i + 1);
        chk("start_in_load_busy", 32'(busy), 1);
      end
    end
  endtask

  task automatic wait_done();
    int old;
    int k;
    old = done_cnt;
    k   = 0;
    while (done_cnt == old && k < 40) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (done_cnt == old) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_vec", 32'(initialState), 0);
    chk("rst_init", 32'(initialize), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ready", 32'(bit_ready), 0);
    chk("rst_idx", 32'(load_idx), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Unstalled load
    exp_q.push_back('{16'hA5C3, 17});
    do_start();
    chk("start_latency_ready", 32'(bit_ready), 1);
    load_pat(16'hA5C3, -1, 0, -1);
    wait_done();

    // Stalled for 3 cycles after bit 5
    exp_q.push_back('{16'hA5C3, 20});
    do_start();
    load_pat(16'hA5C3, 6, 3, -1);
    wait_done();

    // Abort alongside bit 9 of 0x5A3C over a board holding 0xA5C3
    do_start();
    for (int i = 0; i < 9; i++) send_bit(logic'((16'h5A3C >> i) & 16'h1));
    bit_in    = 1'b1;
    bit_valid = 1'b1;
    abort     = 1'b1;
    @(posedge clk); #1;
    abort     = 1'b0;
    bit_valid = 1'b0;
    @(negedge clk);
    chk("abort_init", 32'(initialize), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ready", 32'(bit_ready), 0);
    chk("abort_vec", 32'(initialState), 32'h0000_A43C);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 0);
    end
    @(posedge clk); #1;

    // Asynchronous reset at index 7
    do_start();
    for (int i = 0; i < 7; i++) send_bit(logic'((16'h0F0F >> i) & 16'h1));
    chk("pre_reset_idx", 32'(load_idx), 7);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_vec", 32'(initialState), 0);
    chk("arst_init", 32'(initialize), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_ready", 32'(bit_ready), 0);
    chk("arst_idx", 32'(load_idx), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back('{16'h3C96, 17});
    do_start();
    load_pat(16'h3C96, -1, 0, -1);
    wait_done();

    // start during LOAD and COMMIT ignored; start on the done cycle accepted
    exp_q.push_back('{16'hA5C3, 17});
    exp_q.push_back('{16'h0070, 17});
    do_start();
    load_pat(16'hA5C3, -1, 0, 3);
    start = 1'b1;
    @(negedge clk);
    chk("commit_ready", 32'(bit_ready), 0);
    chk("commit_init", 32'(initialize), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("donecyc_busy", 32'(busy), 0);
    chk("donecyc_init", 32'(initialize), 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("restart_ready", 32'(bit_ready), 1);
    chk("restart_idx", 32'(load_idx), 0);

    // Blinker seed, then free evolution
    load_pat(16'h0070, -1, 0, -1);
    wait_done();
    @(negedge clk);
    chk("blinker_gen1", 32'(board), 32'h0222);
    @(negedge clk);
    chk("blinker_gen2", 32'(board), 32'h0070);
    @(negedge clk);
    chk("blinker_gen3", 32'(board), 32'h0222);

    repeat (4) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
